multiport_memory: RTL and testbench

- Parametrised successor to the LC-3 unified memory: N_READ read ports and 1 write port, selectable read latency (0 = combinational, 1 = registered), and a selectable read-during-write policy.
- Replaces the single-cycle parallel reset load with a sequential init engine. After reset the engine walks every address, loading program words from an external init ROM port and zero-filling the remainder, then asserts ready.
- Sits between the PunC datapath (fetch/load/store) and the init ROM.

---
 rtl/multiport_memory.sv | 128 ++++++++++++
 tb/tb_multiport_memory.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multiport_memory.sv
// Multi-read, single-write word memory with a sequential init engine that
// walks every address after reset, loading ROM words and then zero-filling.

module mpm_rd_lane #(
  parameter int DATA_WIDTH   = 16,
  parameter int READ_LATENCY = 0,
  parameter int WRITE_FIRST  = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  run_i,
  input  logic [DATA_WIDTH-1:0] word_i,
  input  logic                  hit_i,
  input  logic [DATA_WIDTH-1:0] w_data_i,
  output logic [DATA_WIDTH-1:0] r_data_o
);
  logic [DATA_WIDTH-1:0] r_q;

  // The memory array is still pre-write here, so the default path is read-first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                            r_q <= '0;
    else if (!run_i)                    r_q <= '0;
    else if (hit_i && WRITE_FIRST != 0) r_q <= w_data_i;
    else                                r_q <= word_i;
  end

  assign r_data_o = (READ_LATENCY != 0) ? r_q : (run_i ? word_i : '0);
endmodule

module multiport_memory #(
  parameter int N_ELEMENTS   = 128,
  parameter int ADDR_WIDTH   = 16,
  parameter int DATA_WIDTH   = 16,
  parameter int N_READ       = 2,
  parameter int READ_LATENCY = 0,
  parameter int WRITE_FIRST  = 0,
  parameter int INIT_LENGTH  = 22
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_READ*ADDR_WIDTH-1:0] r_addr,
  output logic [N_READ*DATA_WIDTH-1:0] r_data,
  input  logic [ADDR_WIDTH-1:0]        w_addr,
  input  logic [DATA_WIDTH-1:0]        w_data,
  input  logic                         w_en,
  output logic [ADDR_WIDTH-1:0]        init_addr,
  input  logic [DATA_WIDTH-1:0]        init_data,
  output logic                         ready,
  output logic                         w_drop
);
  localparam int IDXW = (N_ELEMENTS > 1) ? $clog2(N_ELEMENTS) : 1;
  localparam logic [ADDR_WIDTH:0] NEL      = (ADDR_WIDTH+1)'(N_ELEMENTS);
  localparam logic [ADDR_WIDTH:0] INIT_LEN = (ADDR_WIDTH+1)'(INIT_LENGTH);

  typedef enum logic {S_INIT, S_RUN} state_e;

  state_e                state_q;
  logic [ADDR_WIDTH:0]   cnt_q;
  logic                  ready_q;
  logic                  w_drop_q;
  logic [DATA_WIDTH-1:0] mem [N_ELEMENTS];

  logic                  w_in_rng;
  logic                  w_ok;
  logic                  run;
  logic [DATA_WIDTH-1:0] init_fill;

  assign w_in_rng  = {1'b0, w_addr} < NEL;
  assign run       = (state_q == S_RUN);
  assign w_ok      = run && w_en && w_in_rng;
  assign init_fill = (cnt_q < INIT_LEN) ? init_data : '0;
  assign init_addr = run ? '0 : cnt_q[ADDR_WIDTH-1:0];
  assign ready     = ready_q;
  assign w_drop    = w_drop_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_INIT;
      cnt_q    <= '0;
      ready_q  <= 1'b0;
      w_drop_q <= 1'b0;
    end else begin
      case (state_q)
        S_INIT: begin
          cnt_q    <= cnt_q + 1'b1;
          w_drop_q <= w_en;
          if (cnt_q == NEL - 1'b1) begin
            state_q <= S_RUN;
            ready_q <= 1'b1;
          end
        end
        default: w_drop_q <= w_en && !w_in_rng;
      endcase
    end
  end

  // No reset on the array: contents survive reset until the init walk rewrites them.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (!run)      mem[cnt_q[IDXW-1:0]]  <= init_fill;
      else if (w_ok) mem[w_addr[IDXW-1:0]] <= w_data;
    end
  end

  for (genvar k = 0; k < N_READ; k++) begin : g_lane
    logic [ADDR_WIDTH-1:0] a;
    logic                  in_rng;
    logic [DATA_WIDTH-1:0] word;

    assign a      = r_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
    assign in_rng = {1'b0, a} < NEL;
    assign word   = in_rng ? mem[a[IDXW-1:0]] : '0;

    mpm_rd_lane #(
      .DATA_WIDTH  (DATA_WIDTH),
      .READ_LATENCY(READ_LATENCY),
      .WRITE_FIRST (WRITE_FIRST)
    ) u_lane (
      .clk     (clk),
      .rst     (rst),
      .run_i   (run),
      .word_i  (word),
      .hit_i   (w_ok && (w_addr == a)),
      .w_data_i(w_data),
      .r_data_o(r_data[k*DATA_WIDTH +: DATA_WIDTH])
    );
  end
endmodule

// File: tb/tb_multiport_memory.sv
// Bench for multiport_memory: three instances (combinational, registered
// write-first, registered read-first) share stimulus; a queue holds expected reads.

module tb_multiport_memory;
  localparam int AW = 16, DW = 16, NE = 128, NR = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [NR*AW-1:0] r_addr;
  logic [AW-1:0]    w_addr;
  logic [DW-1:0]    w_data;
  logic             w_en;
  logic [NR*DW-1:0] rd0, rd1, rd2;
  logic [AW-1:0]    ia0, ia1, ia2;
  logic             rdy0, rdy1, rdy2, wd0, wd1, wd2;

  int n_checks = 0;
  int n_fail   = 0;
  logic [DW-1:0] sb[$];

  // Init ROM: known words in the program area, junk beyond INIT_LENGTH.
  function automatic logic [DW-1:0] rom(input logic [AW-1:0] a);
    if (a == 0)       return 16'h2011;
    else if (a == 18) return 16'h0019;
    else if (a < 22)  return 16'h1000 + a;
    else              return 16'hDEAD;
  endfunction

  multiport_memory #(.N_ELEMENTS(NE), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .N_READ(NR),
    .READ_LATENCY(0), .WRITE_FIRST(0), .INIT_LENGTH(22)) dut0 (
    .clk(clk), .rst(rst), .r_addr(r_addr), .r_data(rd0), .w_addr(w_addr), .w_data(w_data),
    .w_en(w_en), .init_addr(ia0), .init_data(rom(ia0)), .ready(rdy0), .w_drop(wd0));

  multiport_memory #(.N_ELEMENTS(NE), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .N_READ(NR),
    .READ_LATENCY(1), .WRITE_FIRST(1), .INIT_LENGTH(22)) dut1 (
    .clk(clk), .rst(rst), .r_addr(r_addr), .r_data(rd1), .w_addr(w_addr), .w_data(w_data),
    .w_en(w_en), .init_addr(ia1), .init_data(rom(ia1)), .ready(rdy1), .w_drop(wd1));

  multiport_memory #(.N_ELEMENTS(NE), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .N_READ(NR),
    .READ_LATENCY(1), .WRITE_FIRST(0), .INIT_LENGTH(22)) dut2 (
    .clk(clk), .rst(rst), .r_addr(r_addr), .r_data(rd2), .w_addr(w_addr), .w_data(w_data),
    .w_en(w_en), .init_addr(ia2), .init_data(rom(ia2)), .ready(rdy2), .w_drop(wd2));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_r(input int p, input logic [AW-1:0] a);
    r_addr[p*AW +: AW] = a;
  endtask

  task automatic test_reset;
    logic [DW-1:0] e;
    w_en = 0; w_addr = 0; w_data = 0; r_addr = '0;
    #1 rst = 1'b1;
    #1;
    n_checks++; if (rdy0 !== 1'b0) begin n_fail++; $display("FAIL reset_ready got=%b exp=0", rdy0); end
    n_checks++; if (wd0 !== 1'b0) begin n_fail++; $display("FAIL reset_wdrop got=%b exp=0", wd0); end
    n_checks++; if (ia0 !== 16'h0) begin n_fail++; $display("FAIL reset_init_addr got=%h exp=0", ia0); end
    n_checks++; if (rd1 !== '0) begin n_fail++; $display("FAIL reset_rdata_reg got=%h exp=0", rd1); end
    tick();
    rst = 1'b0;
    for (int i = 1; i <= NE; i++) begin
      if (i == 11) begin w_en = 1; w_addr = 15; w_data = 16'hFFFF; end
      if (i == 12) w_en = 0;
      if (i == 50) set_r(0, 0);
      tick();
      n_checks++;
      if (rdy0 !== (i == NE)) begin
        n_fail++; $display("FAIL init_ready edge=%0d got=%b exp=%b", i, rdy0, (i == NE));
      end
      if (i == 11) begin
        n_checks++; if (wd0 !== 1'b1) begin n_fail++; $display("FAIL init_wdrop_pulse got=%b exp=1", wd0); end
      end
      if (i == 12) begin
        n_checks++; if (wd0 !== 1'b0) begin n_fail++; $display("FAIL init_wdrop_clear got=%b exp=0", wd0); end
      end
      if (i == 50) begin
        sb.push_back('0);
        e = sb.pop_front();
        n_checks++; if (rd0[0 +: DW] !== e) begin n_fail++; $display("FAIL init_read_zero got=%h exp=%h", rd0[0 +: DW], e); end
      end
    end
  endtask

  task automatic test_init_load;
    logic [AW-1:0] addrs [5] = '{16'd0, 16'd18, 16'd22, 16'd127, 16'd15};
    logic [DW-1:0] exps  [5] = '{16'h2011, 16'h0019, 16'h0000, 16'h0000, 16'h100F};
    logic [DW-1:0] e;
    for (int j = 0; j < 5; j++) begin
      set_r(0, addrs[j]); set_r(1, addrs[j]);
      repeat (4) sb.push_back(exps[j]);
      #1;
      e = sb.pop_front(); n_checks++;
      if (rd0[0 +: DW] !== e) begin n_fail++; $display("FAIL load_l0_p0 addr=%0d got=%h exp=%h", addrs[j], rd0[0 +: DW], e); end
      e = sb.pop_front(); n_checks++;
      if (rd0[DW +: DW] !== e) begin n_fail++; $display("FAIL load_l0_p1 addr=%0d got=%h exp=%h", addrs[j], rd0[DW +: DW], e); end
      tick();
      e = sb.pop_front(); n_checks++;
      if (rd1[0 +: DW] !== e) begin n_fail++; $display("FAIL load_l1wf_p0 addr=%0d got=%h exp=%h", addrs[j], rd1[0 +: DW], e); end
      e = sb.pop_front(); n_checks++;
      if (rd2[DW +: DW] !== e) begin n_fail++; $display("FAIL load_l1rf_p1 addr=%0d got=%h exp=%h", addrs[j], rd2[DW +: DW], e); end
    end
  endtask

  task automatic test_write_read;
    logic [DW-1:0] e;
    set_r(0, 5); set_r(1, 7);
    w_en = 1; w_addr = 5; w_data = 16'hBEEF;
    sb.push_back(16'h1005);
    #1;
    e = sb.pop_front(); n_checks++;
    if (rd0[0 +: DW] !== e) begin n_fail++; $display("FAIL wr_same_cycle_old got=%h exp=%h", rd0[0 +: DW], e); end
    sb.push_back(16'hBEEF);
    sb.push_back(16'h1005);
    tick();
    e = sb.pop_front(); n_checks++;
    if (rd1[0 +: DW] !== e) begin n_fail++; $display("FAIL wr_l1_write_first got=%h exp=%h", rd1[0 +: DW], e); end
    e = sb.pop_front(); n_checks++;
    if (rd2[0 +: DW] !== e) begin n_fail++; $display("FAIL wr_l1_read_first got=%h exp=%h", rd2[0 +: DW], e); end
    w_en = 0; set_r(0, 5); set_r(1, 5);
    sb.push_back(16'hBEEF); sb.push_back(16'hBEEF);
    #1;
    e = sb.pop_front(); n_checks++;
    if (rd0[0 +: DW] !== e) begin n_fail++; $display("FAIL wr_next_p0 got=%h exp=%h", rd0[0 +: DW], e); end
    e = sb.pop_front(); n_checks++;
    if (rd0[DW +: DW] !== e) begin n_fail++; $display("FAIL wr_next_p1 got=%h exp=%h", rd0[DW +: DW], e); end
    tick();
  endtask

  task automatic test_rdw;
    logic [DW-1:0] e;
    w_en = 1; w_addr = 9; w_data = 16'h1111; set_r(1, 0);
    tick();
    w_data = 16'h2222; set_r(1, 9);
    sb.push_back(16'h1111);
    #1;
    e = sb.pop_front(); n_checks++;
    if (rd0[DW +: DW] !== e) begin n_fail++; $display("FAIL rdw_l0_old got=%h exp=%h", rd0[DW +: DW], e); end
    sb.push_back(16'h2222); sb.push_back(16'h1111);
    tick();
    w_en = 0;
    e = sb.pop_front(); n_checks++;
    if (rd1[DW +: DW] !== e) begin n_fail++; $display("FAIL rdw_write_first got=%h exp=%h", rd1[DW +: DW], e); end
    e = sb.pop_front(); n_checks++;
    if (rd2[DW +: DW] !== e) begin n_fail++; $display("FAIL rdw_read_first got=%h exp=%h", rd2[DW +: DW], e); end
    sb.push_back(16'h2222);
    #1;
    e = sb.pop_front(); n_checks++;
    if (rd0[DW +: DW] !== e) begin n_fail++; $display("FAIL rdw_l0_after got=%h exp=%h", rd0[DW +: DW], e); end
    tick();
  endtask

  task automatic test_drops;
    logic [DW-1:0] e;
    w_en = 1; w_addr = 72; w_data = 16'h7272;
    tick();
    n_checks++; if (wd0 !== 1'b0) begin n_fail++; $display("FAIL drop_inrange_no_pulse got=%b exp=0", wd0); end
    w_addr = 200; w_data = 16'hAAAA;
    tick();
    w_en = 0;
    n_checks++; if (wd0 !== 1'b1) begin n_fail++; $display("FAIL drop_pulse_l0 got=%b exp=1", wd0); end
    n_checks++; if (wd1 !== 1'b1) begin n_fail++; $display("FAIL drop_pulse_l1 got=%b exp=1", wd1); end
    set_r(0, 200); set_r(1, 72);
    sb.push_back(16'h0000); sb.push_back(16'h7272);
    #1;
    e = sb.pop_front(); n_checks++;
    if (rd0[0 +: DW] !== e) begin n_fail++; $display("FAIL drop_read_oor_l0 got=%h exp=%h", rd0[0 +: DW], e); end
    e = sb.pop_front(); n_checks++;
    if (rd0[DW +: DW] !== e) begin n_fail++; $display("FAIL drop_mem_unchanged got=%h exp=%h", rd0[DW +: DW], e); end
    sb.push_back(16'h0000); sb.push_back(16'h7272);
    tick();
    n_checks++; if (wd0 !== 1'b0) begin n_fail++; $display("FAIL drop_pulse_end got=%b exp=0", wd0); end
    e = sb.pop_front(); n_checks++;
    if (rd1[0 +: DW] !== e) begin n_fail++; $display("FAIL drop_read_oor_l1 got=%h exp=%h", rd1[0 +: DW], e); end
    e = sb.pop_front(); n_checks++;
    if (rd1[DW +: DW] !== e) begin n_fail++; $display("FAIL drop_l1_unchanged got=%h exp=%h", rd1[DW +: DW], e); end
  endtask

  task automatic test_reset_run_l1;
    logic [DW-1:0] e;
    bit done;
    set_r(0, 0);
    sb.push_back(16'h2011);
    tick();
    e = sb.pop_front(); n_checks++;
    if (rd1[0 +: DW] !== e) begin n_fail++; $display("FAIL rstrun_pre got=%h exp=%h", rd1[0 +: DW], e); end
    #2 rst = 1'b1;
    #1;
    n_checks++; if (rd1[0 +: DW] !== 16'h0) begin n_fail++; $display("FAIL rstrun_rdata got=%h exp=0", rd1[0 +: DW]); end
    n_checks++; if (rdy1 !== 1'b0) begin n_fail++; $display("FAIL rstrun_ready got=%b exp=0", rdy1); end
    #1 rst = 1'b0;
    done = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      tick();
      if (rdy1) done = 1;
    end
    n_checks++; if (!done) begin n_fail++; $display("FAIL rstrun_reinit_timeout got=0 exp=1"); end
  endtask

  task automatic test_reset_mid_init;
    int edges;
    bit found;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      tick();
      if (ia0 == 40) found = 1;
    end
    n_checks++; if (!found) begin n_fail++; $display("FAIL midinit_reach40 got=%0d exp=40", ia0); end
    rst = 1'b1;
    #1;
    n_checks++; if (ia0 !== 16'h0) begin n_fail++; $display("FAIL midinit_addr_reset got=%h exp=0", ia0); end
    n_checks++; if (rdy0 !== 1'b0) begin n_fail++; $display("FAIL midinit_ready got=%b exp=0", rdy0); end
    #1 rst = 1'b0;
    edges = 0;
    for (int i = 1; i <= 200 && edges == 0; i++) begin
      tick();
      if (rdy0) edges = i;
    end
    n_checks++; if (edges != NE) begin n_fail++; $display("FAIL midinit_full_walk got=%0d exp=%0d", edges, NE); end
  endtask

  initial begin
    test_reset();
    test_init_load();
    test_write_read();
    test_rdw();
    test_drops();
    test_reset_run_l1();
    test_reset_mid_init();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
